msx_timer_multi: RTL and testbench

Parametrised multi-channel interval timer on the MSX I/O bus, successor to the four-channel 8-bit `msx_timer`. It provides up to 8 channels with counters 8 to 24 bits wide, one-shot or periodic (auto-reload) mode, a per-channel resolution prescaler, an overrun flag, and atomic multi-byte count commit and latch. It sits on the cartridge I/O bus beside the other I/O peripherals and drives the shared interrupt line.

---
 rtl/msx_timer_multi_pkg.sv | 27 ++
 rtl/msx_timer_multi_if.sv | 18 +
 rtl/msx_timer_multi_channel.sv | 94 +++++++++
 rtl/msx_timer_multi.sv | 113 +++++++++++
 tb/tb_msx_timer_multi.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msx_timer_multi_pkg.sv
// Shared constants for the multi-channel MSX interval timer: bus offsets,
// indexed register numbers and MODE/CONTROL bit positions.
package msx_timer_pkg;

  localparam logic [1:0] OFF_INDEX  = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_LATCH  = 2'd3;

  localparam logic [2:0] REG_MODE = 3'd0;

  localparam int MODE_IE       = 7;
  localparam int MODE_RESO_LSB = 4;
  localparam int MODE_PERIODIC = 0;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_OVR   = 7;

  localparam int STATUS_W = 8;

  // CONTROL sits directly after the NB target bytes.
  function automatic logic [2:0] ctrl_reg(input int nb);
    return 3'(nb + 1);
  endfunction

endpackage

// File: rtl/msx_timer_multi_if.sv
// MSX I/O bus as seen by the timer. A transfer happens in every cycle with
// ioreq & valid high and an in-range address; ready is 1 whenever out of
// reset, read data returns with rdata_en one cycle after acceptance.
interface msx_timer_multi_if;
  logic       ioreq;
  logic [7:0] address;
  logic       write;
  logic       valid;
  logic       ready;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_en;

  modport master (output ioreq, address, write, valid, wdata,
                  input  ready, rdata, rdata_en);
  modport slave  (input  ioreq, address, write, valid, wdata,
                  output ready, rdata, rdata_en);
endinterface

// File: rtl/msx_timer_multi_channel.sv
// One timer channel: counter, target with staged multi-byte commit, MODE,
// RUN, expiry flag and overrun status.
module msx_timer_channel
  import msx_timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   us_tick,
  input  logic [6:0]             div,
  input  logic                   wr_en,
  input  logic [2:0]             reg_sel,
  input  logic [7:0]             wdata,
  input  logic                   stat_clr,
  output logic [7:0]             rd_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   flag,
  output logic                   ie
);
  localparam int NB = COUNT_WIDTH / 8;

  logic [7:0]             mode;
  logic [COUNT_WIDTH-1:0] target, staging, staged_next;
  logic                   run, ovr;
  logic [2:0]             reso;
  logic [6:0]             mask;
  logic                   chan_tick, expire, wr_mode, wr_tgt, wr_ctrl;

  assign reso = mode[MODE_RESO_LSB +: 3];
  assign ie   = mode[MODE_IE];
  // RESO=0 gives an all-zero mask, so every base tick qualifies.
  assign mask      = 7'((8'd1 << reso) - 8'd1);
  assign chan_tick = us_tick && ((div & mask) == mask);
  assign expire    = chan_tick && run && (({1'b0, count} + 1'b1) >= {1'b0, target});

  assign wr_mode = wr_en && (reg_sel == REG_MODE);
  assign wr_tgt  = wr_en && (reg_sel != REG_MODE) && (reg_sel <= 3'(NB));
  assign wr_ctrl = wr_en && (reg_sel == ctrl_reg(NB));

  always_comb begin
    staged_next = staging;
    for (int b = 0; b < NB; b++)
      if (reg_sel == 3'(b + 1)) staged_next[8*b +: 8] = wdata;
  end

  always_comb begin
    rd_data = '0;
    if (reg_sel == REG_MODE) rd_data = mode;
    if (reg_sel == ctrl_reg(NB)) begin
      rd_data[CTRL_OVR] = ovr;
      rd_data[CTRL_RUN] = run;
    end
    for (int b = 0; b < NB; b++)
      if (reg_sel == 3'(b + 1)) rd_data = target[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= '0;
      target  <= '0;
      staging <= '0;
      count   <= '0;
      run     <= 1'b0;
      flag    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (chan_tick && run) begin
        if (expire) begin
          if (mode[MODE_PERIODIC]) count <= '0;
          else begin
            count <= target;
            run   <= 1'b0;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
      // Bus writes come after the tick so CLEAR and RUN override it.
      if (wr_mode) mode <= wdata;
      if (wr_tgt) begin
        staging <= staged_next;
        if (reg_sel == 3'(NB)) target <= staged_next;
      end
      if (wr_ctrl) begin
        run <= wdata[CTRL_RUN];
        if (wdata[CTRL_CLEAR]) count <= '0;
      end
      flag <= (flag & ~stat_clr) | expire;
      ovr  <= (ovr & ~(wr_ctrl & wdata[CTRL_OVR])) | (expire & flag);
    end
  end

endmodule

// File: rtl/msx_timer_multi.sv
// Multi-channel interval timer top: bus decode, INDEX register, microsecond
// prescaler, count latch and read mux around CHANNELS timer channels.
module msx_timer_multi
  import msx_timer_pkg::*;
#(
  parameter int         CHANNELS    = 4,
  parameter int         COUNT_WIDTH = 16,
  parameter logic [7:0] BASE_ADDR   = 8'hB0,
  parameter int         US_DIV      = 86
) (
  input  logic              clk,
  input  logic              reset,
  msx_timer_multi_if.slave  bus,
  output logic              intr_n
);
  localparam int NB = COUNT_WIDTH / 8;
  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  logic [7:0]             off, index, rd_val, data_sel, latch_byte;
  logic                   accept, wr, rd;
  logic [2:0]             idx_ch, idx_reg;
  logic [PW-1:0]          us_cnt;
  logic                   us_tick;
  logic [6:0]             div;
  logic [COUNT_WIDTH-1:0] snap, snap_sel;
  logic [1:0]             ptr;
  logic [STATUS_W-1:0]    status;
  logic [CHANNELS-1:0]    flag, ie;
  logic [7:0]             ch_rd [CHANNELS];
  logic [COUNT_WIDTH-1:0] count [CHANNELS];

  assign off     = bus.address - BASE_ADDR;
  assign accept  = bus.ioreq && bus.valid && (off[7:2] == 6'd0);
  assign wr      = accept && bus.write;
  assign rd      = accept && !bus.write;
  assign idx_ch  = index[6:4];
  assign idx_reg = index[2:0];
  assign us_tick = (us_cnt == PW'(US_DIV - 1));
  assign intr_n  = ~|(flag & ie);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    msx_timer_channel #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .us_tick  (us_tick),
      .div      (div),
      .wr_en    (wr && (off[1:0] == OFF_DATA) && (idx_ch == 3'(i))),
      .reg_sel  (idx_reg),
      .wdata    (bus.wdata),
      .stat_clr (wr && (off[1:0] == OFF_STATUS) && bus.wdata[i]),
      .rd_data  (ch_rd[i]),
      .count    (count[i]),
      .flag     (flag[i]),
      .ie       (ie[i])
    );
  end

  always_comb begin
    data_sel = '0;
    snap_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_ch == 3'(i)) data_sel = ch_rd[i];
      if (bus.wdata[2:0] == 3'(i)) snap_sel = count[i];
    end
    latch_byte = '0;
    for (int b = 0; b < NB; b++)
      if (ptr == 2'(b)) latch_byte = snap[8*b +: 8];
    status = '0;
    status[CHANNELS-1:0] = flag;
    case (off[1:0])
      OFF_INDEX:  rd_val = index;
      OFF_DATA:   rd_val = data_sel;
      OFF_STATUS: rd_val = status;
      default:    rd_val = latch_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      us_cnt <= '0;
      div    <= '0;
    end else if (us_tick) begin
      us_cnt <= '0;
      div    <= div + 1'b1;
    end else begin
      us_cnt <= us_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index        <= '0;
      snap         <= '0;
      ptr          <= '0;
      bus.ready    <= 1'b0;
      bus.rdata    <= '0;
      bus.rdata_en <= 1'b0;
    end else begin
      bus.ready    <= 1'b1;
      bus.rdata_en <= rd;
      bus.rdata    <= rd ? rd_val : 8'h00;
      if (wr && (off[1:0] == OFF_INDEX)) index <= bus.wdata;
      // Counters update on the same edge, so this captures the pre-tick value.
      if (wr && (off[1:0] == OFF_LATCH)) begin
        snap <= snap_sel;
        ptr  <= '0;
      end
      if (rd && (off[1:0] == OFF_LATCH))
        ptr <= (ptr == 2'(NB - 1)) ? 2'd0 : ptr + 2'd1;
    end
  end

endmodule

// File: tb/tb_msx_timer_multi.sv
// Bench for msx_timer_multi: directed scenarios plus random register traffic,
// checked against a microsecond-level reference model of the timer rules.
module tb_msx_timer_multi;
  localparam int         CH     = 4;
  localparam int         CW     = 16;
  localparam int         NB     = CW / 8;
  localparam int         US_DIV = 4;
  localparam logic [7:0] BASE   = 8'hB0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic intr_n;
  always #5 clk = ~clk;

  msx_timer_multi_if bus_if ();

  msx_timer_multi #(.CHANNELS(CH), .COUNT_WIDTH(CW), .BASE_ADDR(BASE), .US_DIV(US_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .intr_n (intr_n)
  );

  // reference model state
  logic [7:0] m_mode [CH];
  int         m_target [CH];
  int         m_staging [CH];
  int         m_count [CH];
  bit         m_run [CH];
  bit         m_flag [CH];
  bit         m_ovr [CH];
  logic [7:0] m_index;
  int         m_snap, m_ptr, k;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // k counts clock edges since reset release; base tick n happens on edge
  // k = n*US_DIV + US_DIV-1, and a channel with RESO r ticks on every 2^r-th.
  task automatic model_edge();
    int off, ch, r, per, sh, li, usn;
    bit acc, wr, rd, ust, ctrl_wr, oldf;
    bit trun [CH];
    bit expd [CH];
    int pre [CH];
    logic [7:0] rv, wd;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = '0; m_target[c] = 0; m_staging[c] = 0; m_count[c] = 0;
        m_run[c] = 0; m_flag[c] = 0; m_ovr[c] = 0;
      end
      m_index = '0; m_snap = 0; m_ptr = 0; k = 0;
      return;
    end
    off = int'(bus_if.address) - int'(BASE);
    acc = bus_if.ioreq && bus_if.valid && off >= 0 && off < 4;
    wr  = acc && bus_if.write;
    rd  = acc && !bus_if.write;
    wd  = bus_if.wdata;
    ch  = int'(m_index[6:4]);
    r   = int'(m_index[2:0]);
    ust = (k % US_DIV) == US_DIV - 1;
    usn = k / US_DIV;
    for (int c = 0; c < CH; c++) begin
      per     = 1 << m_mode[c][6:4];
      trun[c] = ust && (usn % per == per - 1) && m_run[c];
      expd[c] = trun[c] && (m_count[c] + 1 >= m_target[c]);
      pre[c]  = m_count[c];
    end
    if (rd) begin
      rv = 8'h00;
      case (off)
        0: rv = m_index;
        1: if (ch < CH) begin
             if (r == 0) rv = m_mode[ch];
             else if (r <= NB) rv = 8'(m_target[ch] >> (8 * (r - 1)));
             else if (r == NB + 1) rv = {m_ovr[ch], 6'b0, m_run[ch]};
           end
        2: for (int c = 0; c < CH; c++) rv[c] = m_flag[c];
        default: begin
          rv = 8'(m_snap >> (8 * m_ptr));
          m_ptr = (m_ptr + 1) % NB;
        end
      endcase
      exp_q.push_back(rv);
    end
    for (int c = 0; c < CH; c++) begin
      ctrl_wr = wr && off == 1 && ch == c && r == NB + 1;
      if (trun[c]) begin
        if (expd[c]) begin
          if (m_mode[c][0]) m_count[c] = 0;
          else begin
            m_count[c] = m_target[c];
            m_run[c] = 0;
          end
        end else m_count[c]++;
      end
      oldf = m_flag[c];
      m_flag[c] = (m_flag[c] && !(wr && off == 2 && wd[c])) || expd[c];
      m_ovr[c]  = (m_ovr[c] && !(ctrl_wr && wd[7])) || (expd[c] && oldf);
    end
    if (wr) begin
      case (off)
        0: m_index = wd;
        1: if (ch < CH) begin
             if (r == 0) m_mode[ch] = wd;
             else if (r <= NB) begin
               sh = 8 * (r - 1);
               m_staging[ch] = (m_staging[ch] & ~(255 << sh)) | (int'(wd) << sh);
               if (r == NB) m_target[ch] = m_staging[ch];
             end else if (r == NB + 1) begin
               m_run[ch] = wd[0];
               if (wd[1]) m_count[ch] = 0;
             end
           end
        3: begin
          li = int'(wd[2:0]);
          m_snap = (li < CH) ? pre[li] : 0;
          m_ptr = 0;
        end
        default: ;
      endcase
    end
    k++;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // scoreboard monitor
  initial begin
    bit any;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready", 8'(bus_if.ready), 8'(k > 0));
      any = 0;
      for (int c = 0; c < CH; c++) any = any | (m_flag[c] & m_mode[c][7]);
      check("intr_n", 8'(intr_n), 8'(!any));
      if (bus_if.rdata_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rdata_unexpected: got %02h with no read pending at %0t", bus_if.rdata, $time);
        end else begin
          check("rdata", bus_if.rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_en", 8'(bus_if.rdata_en), 8'h00);
        check("rdata_idle", bus_if.rdata, 8'h00);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_acc(input logic wr, input int off, input logic [7:0] d);
    @(negedge clk);
    bus_if.ioreq   = 1'b1;
    bus_if.valid   = 1'b1;
    bus_if.write   = wr;
    bus_if.address = BASE + 8'(off);
    bus_if.wdata   = d;
    @(negedge clk);
    bus_if.ioreq = 1'b0;
    bus_if.valid = 1'b0;
    bus_if.write = 1'b0;
  endtask

  task automatic bus_wr(input int off, input logic [7:0] d);
    bus_acc(1'b1, off, d);
  endtask

  task automatic bus_rd(input int off);
    bus_acc(1'b0, off, 8'h00);
  endtask

  task automatic set_idx(input int ch, input int r);
    bus_wr(0, {1'b0, 3'(ch), 1'b0, 3'(r)});
  endtask

  task automatic wr_reg(input int ch, input int r, input logic [7:0] d);
    set_idx(ch, r);
    bus_wr(1, d);
  endtask

  task automatic rd_reg(input int ch, input int r);
    set_idx(ch, r);
    bus_rd(1);
  endtask

  task automatic set_target(input int ch, input int t);
    wr_reg(ch, 1, 8'(t));
    wr_reg(ch, 2, 8'(t >> 8));
  endtask

  task automatic latch_read(input int ch);
    bus_wr(3, 8'(ch));
    bus_rd(3);
    bus_rd(3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
    idle(2);
  endtask

  initial begin
    logic [7:0] v;
    bus_if.ioreq = 1'b0; bus_if.valid = 1'b0; bus_if.write = 1'b0;
    bus_if.address = 8'h00; bus_if.wdata = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(2);
    // reset state
    bus_rd(0); bus_rd(2); bus_rd(3); rd_reg(0, 0); rd_reg(0, 3);

    // one-shot, interrupt, stable latch, status clear
    wr_reg(0, 0, 8'h80);
    set_target(0, 10);
    wr_reg(0, 3, 8'h01);
    idle(60);
    bus_rd(2);
    latch_read(0);
    idle(800);
    latch_read(0);
    bus_wr(2, 8'h01);
    bus_rd(2);

    // extend target while running
    set_target(1, 10);
    wr_reg(1, 3, 8'h01);
    idle(12);
    set_target(1, 20);
    idle(100);
    latch_read(1);
    latch_read(1);
    rd_reg(1, 3);

    // periodic with overrun and OVR clear
    wr_reg(2, 0, 8'h81);
    set_target(2, 5);
    wr_reg(2, 3, 8'h01);
    idle(50);
    bus_rd(2);
    rd_reg(2, 3);
    wr_reg(2, 3, 8'h81);
    rd_reg(2, 3);

    // atomic commit of the target
    set_target(3, 16'h0100);
    wr_reg(3, 3, 8'h01);
    wr_reg(3, 1, 8'h02);
    idle(400);
    bus_rd(2);
    rd_reg(3, 1);
    wr_reg(3, 2, 8'h00);
    idle(12);
    bus_rd(2);
    rd_reg(3, 3);

    // resolution prescaler: CLEAR and RUN together
    bus_wr(2, 8'h0F);
    wr_reg(0, 0, 8'hB0);
    set_target(0, 4);
    wr_reg(0, 3, 8'h03);
    for (int i = 0; i < 6; i++) begin
      idle(20);
      bus_rd(2);
    end

    // out-of-range channel and register
    wr_reg(5, 0, 8'h81);
    rd_reg(5, 0);
    rd_reg(0, 6);
    bus_rd(0);

    // reset while three channels run
    for (int c = 0; c < 3; c++) begin
      set_target(c, 200);
      wr_reg(c, 0, 8'h80);
      wr_reg(c, 3, 8'h01);
    end
    idle(30);
    do_reset(3);
    bus_rd(2); bus_rd(0); bus_rd(3); rd_reg(1, 3); rd_reg(2, 1);

    // random traffic
    for (int c = 0; c < CH; c++) begin
      wr_reg(c, 0, {1'b1, 3'($urandom_range(0, 2)), 3'b0, 1'($urandom_range(0, 1))});
      set_target(c, $urandom_range(0, 12));
      wr_reg(c, 3, 8'h03);
    end
    for (int n = 0; n < 160; n++) begin
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
      case ($urandom_range(0, 7))
        0: set_idx($urandom_range(0, 5), $urandom_range(0, 4));
        1, 2: bus_wr(1, v);
        3: bus_wr(2, 8'($urandom_range(0, 255)));
        4: bus_wr(3, 8'($urandom_range(0, 5)));
        5: bus_rd($urandom_range(0, 3));
        6: bus_rd(1);
        default: idle($urandom_range(1, 30));
      endcase
    end
    for (int c = 0; c < CH; c++)
      for (int r = 0; r <= NB + 1; r++) rd_reg(c, r);
    bus_rd(2);

    idle(4);
    check("drain", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
